// File: rtl/br_tag_alloc_mw.sv
// br_tag_alloc_mw: multi-lane branch tag allocator.
// Hands out one-hot branch tags to in-order dispatch lanes and tracks the
// live-tag set. It retires tags on correct resolution and rolls the set back
// on misprediction. Clear/squash broadcasts are registered for the RS.
module br_tag_alloc_mw #(
    parameter int BR_DEPTH = 5,
    parameter int DISP_W   = 2,
    parameter int CNT_W    = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DISP_W-1:0]            disp_req_i,
    output logic [DISP_W-1:0]            disp_gnt_o,
    output logic [DISP_W*BR_DEPTH-1:0]   disp_bit_o,
    output logic [DISP_W*BR_DEPTH-1:0]   disp_mask_o,
    input  logic                         res_valid_i,
    input  logic                         res_wrong_i,
    input  logic [BR_DEPTH-1:0]          res_bit_i,
    input  logic [BR_DEPTH-1:0]          res_mask_i,
    output logic                         clr_valid_o,
    output logic [BR_DEPTH-1:0]          clr_bit_o,
    output logic                         squash_valid_o,
    output logic [BR_DEPTH-1:0]          squash_mask_o,
    output logic [BR_DEPTH-1:0]          live_mask_o,
    output logic [CNT_W-1:0]             live_cnt_o,
    output logic                         full_o,
    output logic                         err_o
);

    logic [BR_DEPTH-1:0] live_p1;
    logic                clr_valid_p1;
    logic [BR_DEPTH-1:0] clr_bit_p1;
    logic                squash_valid_p1;
    logic [BR_DEPTH-1:0] squash_mask_p1;
    logic                err_p1;

    logic                res_onehot;
    logic                res_ok;
    logic                res_err;
    logic                res_kill;
    logic [BR_DEPTH-1:0] clr_now;
    logic [BR_DEPTH-1:0] granted_all;

    // Isolate the lowest set bit of a vector.
    function automatic logic [BR_DEPTH-1:0] lowest_bit(input logic [BR_DEPTH-1:0] v);
        logic [BR_DEPTH-1:0] r;
        logic                found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < BR_DEPTH; i++) begin
            if (v[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Classify the incoming resolution: valid, bad (ignored + flagged), kill or clear.
    always_comb begin
        res_onehot = (res_bit_i != '0) && ((res_bit_i & (res_bit_i - 1'b1)) == '0);
        res_ok     = res_valid_i && res_onehot && ((res_bit_i & live_p1) != '0);
        res_err    = res_valid_i && !res_ok;
        res_kill   = res_ok && res_wrong_i;
        clr_now    = (res_ok && !res_wrong_i) ? res_bit_i : '0;
    end

    // In-order lane grant: lowest free tag to the oldest lane, stop at the first refused requester.
    always_comb begin
        logic [BR_DEPTH-1:0] free;
        logic [BR_DEPTH-1:0] acc;
        logic [BR_DEPTH-1:0] base;
        logic [BR_DEPTH-1:0] tag;
        logic                blocked;
        free        = ~live_p1;
        acc         = '0;
        base        = live_p1 & ~clr_now;
        blocked     = 1'b0;
        disp_gnt_o  = '0;
        disp_bit_o  = '0;
        disp_mask_o = '0;
        for (int k = 0; k < DISP_W; k++) begin
            tag = '0;
            if (disp_req_i[k]) begin
                if (!blocked && !res_kill && (free != '0)) begin
                    tag           = lowest_bit(free);
                    disp_gnt_o[k] = 1'b1;
                    free          = free & ~tag;
                end else begin
                    blocked = 1'b1;
                end
            end
            disp_bit_o[k*BR_DEPTH +: BR_DEPTH]  = tag;
            disp_mask_o[k*BR_DEPTH +: BR_DEPTH] = base | acc;
            acc = acc | tag;
        end
        granted_all = acc;
    end

    // Live-tag register and registered clear/squash/error reporting.
    always_ff @(posedge clk) begin
        if (rst) begin
            live_p1         <= '0;
            clr_valid_p1    <= 1'b0;
            clr_bit_p1      <= '0;
            squash_valid_p1 <= 1'b0;
            squash_mask_p1  <= '0;
            err_p1          <= 1'b0;
        end else begin
            if (res_kill) begin
                live_p1 <= live_p1 & res_mask_i & ~res_bit_i;
            end else begin
                live_p1 <= (live_p1 & ~clr_now) | granted_all;
            end
            clr_valid_p1    <= res_ok && !res_wrong_i;
            clr_bit_p1      <= clr_now;
            squash_valid_p1 <= res_kill;
            squash_mask_p1  <= res_kill ? (live_p1 & ~(res_mask_i & ~res_bit_i)) : '0;
            err_p1          <= err_p1 | res_err;
        end
    end

    // Occupancy status derived from the live register.
    always_comb begin
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < BR_DEPTH; i++) begin
            cnt = cnt + CNT_W'(live_p1[i]);
        end
        live_cnt_o = cnt;
        full_o     = &live_p1;
    end

    assign live_mask_o    = live_p1;
    assign clr_valid_o    = clr_valid_p1;
    assign clr_bit_o      = clr_bit_p1;
    assign squash_valid_o = squash_valid_p1;
    assign squash_mask_o  = squash_mask_p1;
    assign err_o          = err_p1;

endmodule

// File: doc/br_tag_alloc_mw.md
Name: br_tag_alloc_mw

Overview:
- Parametrised successor to the single-issue branch-mask controller.
- Allocates one-hot branch tags to up to DISP_W branches dispatched per cycle, in lane order.
- Retires tags on correct resolution; on misprediction, rolls the live-tag mask back to the mispredicted branch's dependency mask.
- Sits between dispatch and ROB/RS/branch stack. Drives the per-lane tag and dependency mask consumed by ROB and stacks, and a registered clear/squash broadcast consumed by RS.

Parameters:
- BR_DEPTH, 5, number of branch tags; width of every mask.
- DISP_W, 2, number of dispatch lanes per cycle (1..4).
- CNT_W, 3, width of the live-tag counter; must satisfy 2^CNT_W > BR_DEPTH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- disp_req_i  in  DISP_W  lane k requests a tag (bit 0 = oldest lane)
- disp_gnt_o  out  DISP_W  lane k granted; combinational
- disp_bit_o  out  DISP_W*BR_DEPTH  one-hot tag per lane, slice k; zero if not granted
- disp_mask_o  out  DISP_W*BR_DEPTH  per-lane dependency mask (tags this branch depends on)
- res_valid_i  in  1  a branch resolves this cycle
- res_wrong_i  in  1  1 = mispredicted, 0 = correct
- res_bit_i  in  BR_DEPTH  one-hot tag of the resolving branch
- res_mask_i  in  BR_DEPTH  dependency mask captured for that branch at its dispatch
- clr_valid_o  out  1  registered: a tag was freed last cycle (correct resolution)
- clr_bit_o  out  BR_DEPTH  registered one-hot freed tag
- squash_valid_o  out  1  registered: misprediction last cycle
- squash_mask_o  out  BR_DEPTH  registered set of tags killed (resolved tag plus all younger tags)
- live_mask_o  out  BR_DEPTH  current live-tag register
- live_cnt_o  out  CNT_W  popcount of live_mask_o
- full_o  out  1  live_mask_o all ones
- err_o  out  1  sticky: res_bit_i not one-hot or not live while res_valid_i

Behaviour:
- Reset: live mask = 0, live_cnt_o = 0, full_o = 0, err_o = 0, clr_valid_o = 0, squash_valid_o = 0, clr_bit_o = 0, squash_mask_o = 0.
- Allocation and grants:
  - Free tags = ~live; allocation uses live as it stands at the start of the cycle.
  - A tag freed this cycle becomes allocatable next cycle only.
  - Lane k is granted iff disp_req_i[k], lanes 0..k-1 are each granted or not requesting, and a free tag remains.
  - Grants are in order: a lane never receives a grant when an older requesting lane does not. Partial grant is allowed.
  - Granted lanes take free tags lowest index first: oldest granted lane gets the lowest free index.
  - Grants and bits are combinational in the same cycle; the live register updates at the next clock edge.
- Dependency mask for lane k = (live & ~clr_now) | tags granted to lanes 0..k-1 this cycle.
  - clr_now = res_bit_i when res_valid_i and !res_wrong_i, else 0.
  - A lane's own tag is excluded from its dependency mask.
- Correct resolution (res_valid_i, !res_wrong_i):
  - next live = (live & ~res_bit_i) | newly granted tags.
  - clr_valid_o and clr_bit_o assert the next cycle for exactly 1 cycle.
- Wrong resolution (res_valid_i, res_wrong_i):
  - All grants are forced to 0 this cycle; disp_bit_o is 0.
  - next live = live & res_mask_i & ~res_bit_i.
  - squash_mask_o = live & ~(res_mask_i & ~res_bit_i), registered; squash_valid_o pulses 1 cycle.
- Error case: if res_valid_i and res_bit_i is not one-hot or not live, the resolution is ignored (no live change, no clr/squash output) and err_o sets. err_o clears only on rst.
- live_cnt_o and full_o are derived combinationally from the live register.
- Reset has priority over all inputs, including a mid-cycle resolution; pending clr/squash outputs are dropped.

Test Plan:
- Reset, then disp_req_i=2'b11 for 3 cycles (BR_DEPTH=5, DISP_W=2) -> cycle 0 bits 00001/00010, masks 00000/00001; cycle 1 bits 00100/01000; cycle 2 only lane 0 granted, bit 10000; full_o=1, live_cnt_o=5.
- Live=11111, correct resolve of 00100 with disp_req_i=2'b01 -> disp_gnt_o=00 that cycle; next cycle live=11011, clr_valid_o=1, clr_bit_o=00100; following cycle lane 0 gets 00100.
- Live=01111, wrong resolve res_bit_i=00010, res_mask_i=00001, disp_req_i=11 -> grants 00; next live=00001; squash_mask_o=01110, squash_valid_o=1 for 1 cycle.
- Live=00011, correct resolve 00001 with disp_req_i=2'b11 -> lane 0 bit 00100 mask 00010; lane 1 bit 01000 mask 00110; next live=01110.
- disp_req_i=2'b10 with live=00000 -> lane 1 granted bit 00001; then res_valid_i with res_bit_i=00110 -> err_o=1, live unchanged.
- Wrong resolve and rst asserted together -> next cycle live=0, squash_valid_o=0, err_o=0.
